// File: rtl/bcd_down_counter_if.sv
// bcd_down_counter_if: control and status bundle for the two-digit BCD
// countdown counter. The controller side drives load/preset/start/stop and
// observes the count and status flags; the counter side is the reverse.
interface bcd_down_counter_if;
    logic       load;
    logic [7:0] preset;
    logic       start;
    logic       stop;
    logic [7:0] q;
    logic       zero;
    logic       done;
    logic       running;
    logic       bad_preset;

    modport master (
        output load, preset, start, stop,
        input  q, zero, done, running, bad_preset
    );

    modport slave (
        input  load, preset, start, stop,
        output q, zero, done, running, bad_preset
    );
endinterface

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: two-digit BCD countdown counter with preset load,
// start/stop control, a TICK_DIV clock-enable prescaler and a one-cycle
// terminal-count pulse.
//
// Optional feature: define AUTO_RELOAD_EN to make a terminal tick reload the
// count from the last valid preset (periodic mode) instead of stopping at 00.
// Without the macro the reload register does not exist.
//
// Behaviour notes:
// - A cycle spent in RUN always advances the prescaler, including the cycle
//   on whose closing edge stop is sampled; the paused value is what resumes.
// - A rejected (invalid) load consumes that cycle's start/stop but does not
//   disturb a count already in progress.
// - A terminal tick wins over a simultaneous stop: the counter ends in DONE.
module bcd_down_counter #(
    parameter int TICK_DIV = 1
) (
    input  logic                clock,
    input  logic                clear,
    bcd_down_counter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(TICK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] pre_q,   pre_d;
    logic       done_q,  done_d;
    logic       bad_q,   bad_d;
`ifdef AUTO_RELOAD_EN
    logic [7:0] reload_q, reload_d;
`endif
    logic       preset_ok;

    // One BCD decrement with borrow from units into tens; saturates at 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0)
            return {v[7:4], v[3:0] - 4'd1};
        else if (v[7:4] != 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return 8'h00;
    endfunction

    // A preset is usable only when both nibbles are decimal digits.
    always_comb begin
        preset_ok = (bus.preset[7:4] <= 4'd9) && (bus.preset[3:0] <= 4'd9);
    end

    // Next-state: load overrides everything; RUN advances the prescaler and
    // ticks; then stop (winning over start) and start act on the state.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pre_d    = pre_q;
        done_d   = 1'b0;
        bad_d    = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (bus.load && preset_ok) begin
            count_d  = bus.preset;
`ifdef AUTO_RELOAD_EN
            reload_d = bus.preset;
`endif
            pre_d    = 8'd0;
            state_d  = IDLE;
        end else begin
            bad_d = bus.load;
            if (state_q == RUN) begin
                if (pre_q == PRE_LAST) begin
                    pre_d = 8'd0;
                    if (count_q == 8'h01) begin
                        done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                        if (reload_q != 8'h00) begin
                            count_d = reload_q;
                        end else begin
                            count_d = 8'h00;
                            state_d = DONE;
                        end
`else
                        count_d = 8'h00;
                        state_d = DONE;
`endif
                    end else begin
                        count_d = bcd_dec(count_q);
                    end
                end else begin
                    pre_d = pre_q + 8'd1;
                end
            end
            if (!bus.load) begin
                if (bus.stop) begin
                    if (state_q == RUN && state_d == RUN)
                        state_d = HOLD;
                end else if (bus.start) begin
                    if ((state_q == IDLE || state_q == HOLD) && count_q != 8'h00) begin
                        state_d = RUN;
                        if (state_q == IDLE)
                            pre_d = 8'd0;
                    end
                end
            end
        end
    end

    // State, count, prescaler and pulse registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= IDLE;
            count_q  <= 8'h00;
            pre_q    <= 8'd0;
            done_q   <= 1'b0;
            bad_q    <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_q <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            pre_q    <= pre_d;
            done_q   <= done_d;
            bad_q    <= bad_d;
`ifdef AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign bus.q          = count_q;
    assign bus.zero       = (count_q == 8'h00);
    assign bus.done       = done_q;
    assign bus.running    = (state_q == RUN);
    assign bus.bad_preset = bad_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: drives two counters (TICK_DIV=1 and TICK_DIV=4) with
// identical controls. Directed scenarios compare against hand-derived values;
// the random scenario compares against a decimal-integer reference model.
module tb_bcd_down_counter;

    logic clk;
    logic clear;
    int   checks;
    int   errors;

    bcd_down_counter_if if1 ();
    bcd_down_counter_if if4 ();

    bcd_down_counter #(.TICK_DIV(1)) dut1 (.clock(clk), .clear(clear), .bus(if1));
    bcd_down_counter #(.TICK_DIV(4)) dut4 (.clock(clk), .clear(clear), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs gathered per instance (0: TICK_DIV=1, 1: TICK_DIV=4).
    logic [7:0] o_q    [2];
    logic       o_zero [2];
    logic       o_done [2];
    logic       o_run  [2];
    logic       o_bad  [2];
    assign o_q[0] = if1.q;          assign o_q[1] = if4.q;
    assign o_zero[0] = if1.zero;    assign o_zero[1] = if4.zero;
    assign o_done[0] = if1.done;    assign o_done[1] = if4.done;
    assign o_run[0] = if1.running;  assign o_run[1] = if4.running;
    assign o_bad[0] = if1.bad_preset; assign o_bad[1] = if4.bad_preset;

    // Reference model: count kept as a plain decimal integer.
    int divs [2] = '{1, 4};
    int m_v  [2];
    int m_rl [2];
    int m_el [2];
    bit m_run [2];
    bit m_pause [2];
    bit m_fin [2];
    bit m_done [2];
    bit m_bad [2];

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic model_update(input logic clr, input logic ld, input logic [7:0] pv,
                                input logic st, input logic sp);
        for (int k = 0; k < 2; k++) begin
            bit ok;
            bit was_run;
            ok = (pv[7:4] <= 4'd9) && (pv[3:0] <= 4'd9);
            m_done[k] = 1'b0;
            m_bad[k]  = 1'b0;
            if (clr) begin
                m_v[k] = 0; m_rl[k] = 0; m_el[k] = 0;
                m_run[k] = 1'b0; m_pause[k] = 1'b0; m_fin[k] = 1'b0;
            end else if (ld && ok) begin
                m_v[k] = bcd2i(pv); m_rl[k] = m_v[k]; m_el[k] = 0;
                m_run[k] = 1'b0; m_pause[k] = 1'b0; m_fin[k] = 1'b0;
            end else begin
                m_bad[k] = ld;
                was_run = m_run[k];
                if (was_run) begin
                    m_el[k] = m_el[k] + 1;
                    if (m_el[k] == divs[k]) begin
                        m_el[k] = 0;
                        if (m_v[k] == 1) begin
                            m_done[k] = 1'b1;
`ifdef AUTO_RELOAD_EN
                            if (m_rl[k] != 0) begin
                                m_v[k] = m_rl[k];
                            end else begin
                                m_v[k] = 0; m_run[k] = 1'b0; m_fin[k] = 1'b1;
                            end
`else
                            m_v[k] = 0; m_run[k] = 1'b0; m_fin[k] = 1'b1;
`endif
                        end else begin
                            m_v[k] = m_v[k] - 1;
                        end
                    end
                end
                if (!ld && sp) begin
                    if (was_run && m_run[k]) begin
                        m_run[k] = 1'b0; m_pause[k] = 1'b1;
                    end
                end else if (!ld && st) begin
                    if (!was_run && !m_fin[k] && m_v[k] != 0) begin
                        if (!m_pause[k]) m_el[k] = 0;
                        m_run[k] = 1'b1; m_pause[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    // Apply one cycle of controls to both counters, then sample after the edge.
    task automatic step(input logic clr, input logic ld, input logic [7:0] pv,
                        input logic st, input logic sp);
        clear = clr;
        if1.load = ld;  if1.preset = pv; if1.start = st; if1.stop = sp;
        if4.load = ld;  if4.preset = pv; if4.start = st; if4.stop = sp;
        @(posedge clk);
        model_update(clr, ld, pv, st, sp);
        #1;
    endtask

    task automatic idle(); step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_q[k] !== 8'h00) begin errors++; $display("FAIL reset_q[%0d] got %h want 00", k, o_q[k]); end
            checks++; if (o_zero[k] !== 1'b1) begin errors++; $display("FAIL reset_zero[%0d] got %b want 1", k, o_zero[k]); end
            checks++; if (o_done[k] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d] got %b want 0", k, o_done[k]); end
            checks++; if (o_run[k] !== 1'b0) begin errors++; $display("FAIL reset_running[%0d] got %b want 0", k, o_run[k]); end
            checks++; if (o_bad[k] !== 1'b0) begin errors++; $display("FAIL reset_bad[%0d] got %b want 0", k, o_bad[k]); end
        end
    endtask

    task automatic test_countdown();
        logic [7:0] exp_q;
        logic       exp_run;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
        checks++; if (if1.q !== 8'h12) begin errors++; $display("FAIL cd_load_q got %h want 12", if1.q); end
        checks++; if (if1.running !== 1'b0) begin errors++; $display("FAIL cd_load_running got %b want 0", if1.running); end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (if1.running !== 1'b1) begin errors++; $display("FAIL cd_start_running got %b want 1", if1.running); end
        checks++; if (if1.q !== 8'h12) begin errors++; $display("FAIL cd_start_q got %h want 12", if1.q); end
        for (int i = 1; i <= 12; i++) begin
            idle();
            exp_q = i2bcd(12 - i);
            exp_run = (i < 12);
`ifdef AUTO_RELOAD_EN
            if (i == 12) begin exp_q = 8'h12; exp_run = 1'b1; end
`endif
            checks++; if (if1.q !== exp_q) begin errors++; $display("FAIL cd_q step %0d got %h want %h", i, if1.q, exp_q); end
            checks++; if (if1.done !== (i == 12)) begin errors++; $display("FAIL cd_done step %0d got %b want %b", i, if1.done, (i == 12)); end
            checks++; if (if1.running !== exp_run) begin errors++; $display("FAIL cd_running step %0d got %b want %b", i, if1.running, exp_run); end
        end
        idle();
        checks++; if (if1.done !== 1'b0) begin errors++; $display("FAIL cd_done_after got %b want 0", if1.done); end
`ifndef AUTO_RELOAD_EN
        checks++; if (if1.zero !== 1'b1) begin errors++; $display("FAIL cd_zero_after got %b want 1", if1.zero); end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (if1.running !== 1'b0) begin errors++; $display("FAIL cd_restart_running got %b want 0", if1.running); end
        checks++; if (if1.q !== 8'h00) begin errors++; $display("FAIL cd_restart_q got %h want 00", if1.q); end
`endif
    endtask

    task automatic test_prescaler();
        logic [7:0] exp_q;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            idle();
            exp_q = (k < 4) ? 8'h20 : ((k < 8) ? 8'h19 : 8'h18);
            checks++; if (if4.q !== exp_q) begin errors++; $display("FAIL pre_q edge %0d got %h want %h", k, if4.q, exp_q); end
        end
        // Pause after edge 6, resume three cycles later.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (if4.running !== 1'b0) begin errors++; $display("FAIL pre_stop_running got %b want 0", if4.running); end
        idle(); idle();
        checks++; if (if4.q !== 8'h19) begin errors++; $display("FAIL pre_hold_q got %h want 19", if4.q); end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (if4.running !== 1'b1) begin errors++; $display("FAIL pre_resume_running got %b want 1", if4.running); end
        idle();
        checks++; if (if4.q !== 8'h19) begin errors++; $display("FAIL pre_resume1_q got %h want 19", if4.q); end
        idle();
        checks++; if (if4.q !== 8'h18) begin errors++; $display("FAIL pre_resume2_q got %h want 18", if4.q); end
    endtask

    task automatic test_invalid_preset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h1A, 1'b0, 1'b0);
        checks++; if (if1.bad_preset !== 1'b1) begin errors++; $display("FAIL inv_bad got %b want 1", if1.bad_preset); end
        checks++; if (if4.q !== 8'h05) begin errors++; $display("FAIL inv_q got %h want 05", if4.q); end
        checks++; if (if4.running !== 1'b0) begin errors++; $display("FAIL inv_running got %b want 0", if4.running); end
        idle();
        checks++; if (if1.bad_preset !== 1'b0) begin errors++; $display("FAIL inv_bad_pulse got %b want 0", if1.bad_preset); end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (if1.running !== 1'b1) begin errors++; $display("FAIL inv_start_running got %b want 1", if1.running); end
        step(1'b0, 1'b1, 8'hA0, 1'b0, 1'b0);
        checks++; if (if4.bad_preset !== 1'b1) begin errors++; $display("FAIL inv_run_bad got %b want 1", if4.bad_preset); end
        checks++; if (if4.running !== 1'b1) begin errors++; $display("FAIL inv_run_running got %b want 1", if4.running); end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h50, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (if1.running !== 1'b0) begin errors++; $display("FAIL sim_ss_running got %b want 0", if1.running); end
        checks++; if (if1.q !== 8'h49) begin errors++; $display("FAIL sim_ss_q got %h want 49", if1.q); end
        idle();
        checks++; if (if1.q !== 8'h49) begin errors++; $display("FAIL sim_hold_q got %h want 49", if1.q); end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (if1.running !== 1'b1) begin errors++; $display("FAIL sim_resume_running got %b want 1", if1.running); end
        step(1'b0, 1'b1, 8'h07, 1'b1, 1'b0);
        checks++; if (if1.q !== 8'h07) begin errors++; $display("FAIL sim_ldst_q got %h want 07", if1.q); end
        checks++; if (if1.running !== 1'b0) begin errors++; $display("FAIL sim_ldst_running got %b want 0", if1.running); end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (if1.running !== 1'b0) begin errors++; $display("FAIL sim_idle_ss_running got %b want 0", if1.running); end
        step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        checks++; if (if1.q !== 8'h00) begin errors++; $display("FAIL sim_clrld_q got %h want 00", if1.q); end
    endtask

    task automatic test_midrun_clear();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        checks++; if (if1.q !== 8'h02) begin errors++; $display("FAIL mid_tick_q got %h want 02", if1.q); end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (if1.q !== 8'h00) begin errors++; $display("FAIL mid_clr_q got %h want 00", if1.q); end
        checks++; if (if1.running !== 1'b0) begin errors++; $display("FAIL mid_clr_running got %b want 0", if1.running); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (if1.done !== 1'b0) begin errors++; $display("FAIL mid_done cyc %0d got %b want 0", i, if1.done); end
            idle();
        end
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_autoreload();
        logic [7:0] exp_q;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            idle();
            exp_q = (i % 3 == 0) ? 8'h03 : i2bcd(3 - (i % 3));
            checks++; if (if1.q !== exp_q) begin errors++; $display("FAIL ar_q step %0d got %h want %h", i, if1.q, exp_q); end
            checks++; if (if1.done !== (i % 3 == 0)) begin errors++; $display("FAIL ar_done step %0d got %b want %b", i, if1.done, (i % 3 == 0)); end
            checks++; if (if1.running !== 1'b1) begin errors++; $display("FAIL ar_running step %0d got %b want 1", i, if1.running); end
        end
    endtask
`endif

    task automatic test_random();
        logic       clr, ld, st, sp;
        logic [7:0] pv;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            clr = ($urandom_range(0, 99) < 2);
            ld  = ($urandom_range(0, 99) < 6);
            st  = ($urandom_range(0, 99) < 25);
            sp  = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 9))
                0, 1:    pv = 8'($urandom);
                2, 3, 4: pv = i2bcd($urandom_range(0, 99));
                default: pv = i2bcd($urandom_range(0, 8));
            endcase
            step(clr, ld, pv, st, sp);
            for (int k = 0; k < 2; k++) begin
                checks++; if (o_q[k] !== i2bcd(m_v[k])) begin errors++; $display("FAIL rand_q[%0d] cyc %0d got %h want %h", k, c, o_q[k], i2bcd(m_v[k])); end
                checks++; if (o_zero[k] !== (m_v[k] == 0)) begin errors++; $display("FAIL rand_zero[%0d] cyc %0d got %b want %b", k, c, o_zero[k], (m_v[k] == 0)); end
                checks++; if (o_done[k] !== m_done[k]) begin errors++; $display("FAIL rand_done[%0d] cyc %0d got %b want %b", k, c, o_done[k], m_done[k]); end
                checks++; if (o_run[k] !== m_run[k]) begin errors++; $display("FAIL rand_running[%0d] cyc %0d got %b want %b", k, c, o_run[k], m_run[k]); end
                checks++; if (o_bad[k] !== m_bad[k]) begin errors++; $display("FAIL rand_bad[%0d] cyc %0d got %b want %b", k, c, o_bad[k], m_bad[k]); end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_countdown();
        test_prescaler();
        test_invalid_preset();
        test_simultaneous();
        test_midrun_clear();
`ifdef AUTO_RELOAD_EN
        test_autoreload();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Synchronous two-digit BCD countdown counter with preset load, start/stop control, a clock-enable prescaler and a terminal-count pulse. It is the count-down counterpart of the team's decade up-counter chain: an up chain counts 0→9 and clears, while this block loads a BCD value and counts it down to 00. It is used as a timeout and interval source beside the counter chain, and its 8-bit BCD output has the same digit layout as the up chain.

## Interface
- TICK_DIV, 1: clock cycles per decrement; legal range 1..256.
- clock  input  1  single system clock; all state updates on the rising edge.
- clear  input  1  synchronous, active-high reset.
- load  input  1  load `preset` into the count and the reload register.
- preset  input  8  BCD value to load: [7:4] is tens, [3:0] is units.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- q  output  8  current BCD count.
- zero  output  1  high while q == 8'h00 (combinational from q).
- done  output  1  one-cycle pulse at terminal count.
- running  output  1  high in state RUN.
- bad_preset  output  1  one-cycle pulse when a load is rejected.

## Operation
- States:
  - IDLE: loaded or reset, not counting.
  - RUN: counting.
  - HOLD: paused.
  - DONE: reached 00.
- Priority each cycle: clear > load > stop > start.
- clear:
  - q=00, reload register=00, prescaler=0, state=IDLE.
  - done=0, bad_preset=0, running=0.
- load in any state:
  - Valid preset (both nibbles ≤ 9): q=preset, reload register=preset, prescaler=0, state=IDLE.
  - Invalid preset (either nibble > 9): q, reload register and state unchanged; bad_preset pulses for 1 cycle.
- stop in RUN: go to HOLD; the prescaler value is kept.
- start in IDLE or HOLD with q != 00: go to RUN.
  - From IDLE the prescaler is 0.
  - From HOLD the prescaler resumes from its held value.
- start in DONE, or with q == 00: ignored.
- start and stop asserted together: stop wins. In IDLE or HOLD, nothing happens.
- RUN prescaler:
  - Counts 0..TICK_DIV-1. At TICK_DIV-1 a tick occurs and the prescaler wraps to 0.
  - With TICK_DIV=1, a tick occurs every cycle.
- On each tick:
  - Units != 0: decrement units.
  - Units == 0: units=9 and tens is decremented.
  - q never wraps below 00.
- Terminal count (tick while q == 01): q becomes 00, done=1 in the next cycle, state=DONE.
- In DONE, q holds 00 until load or clear.
- zero is combinational from q. done and bad_preset are registered.

## Timing
- Reset values: q=00, zero=1, done=0, running=0, bad_preset=0.
- start sampled at edge n: running=1 after edge n.
- First decrement is at edge n+TICK_DIV, then every TICK_DIV edges.
- done is high for exactly the one cycle after the edge where q becomes 00. It is never high for 2 consecutive cycles unless TICK_DIV=1 and AUTO_RELOAD_EN reloads 01.
- load takes effect at the next edge. A load during RUN aborts counting, with no done pulse.
- clear during RUN: all outputs reach reset values after that edge. A pending done is suppressed.
- Latency from terminal tick to done is 1 cycle.

## Configuration
- AUTO_RELOAD_EN defined:
  - A terminal tick (q == 01) loads q from the reload register instead of 00.
  - done still pulses and the state stays RUN (periodic mode).
  - If the reload register is 00, terminal behaviour is as without the macro.
- AUTO_RELOAD_EN undefined: the reload register is not implemented and terminal behaviour is as in Operation.

## Test plan
- Reset and load, TICK_DIV=1: clear, load preset=8'h12, start → q goes 12,11,10,09,...,01,00 on consecutive edges; done pulses once with q=00; running=0 afterwards; a further start has no effect.
- Prescaler and borrow, TICK_DIV=4: load 8'h20, start → q=19 after 4 edges and 18 after 8; stop at cycle 6 then start 3 cycles later → next decrement lands 2 running cycles after resume.
- Invalid preset: load 8'h1A while q=05 → bad_preset pulse; q stays 05; state unchanged.
- Simultaneous controls: start+stop in RUN → HOLD; load+start in IDLE → q=preset and stays IDLE; clear+load → q=00.
- Mid-run reset: load 8'h03, start, clear after 1 tick → q=00, done never asserted, running=0.
- AUTO_RELOAD_EN, TICK_DIV=1: load 8'h03, start → q sequence 03,02,01,03,02,01,...; done pulses every 3 cycles; running stays 1.
